// File: rtl/latency_capture.sv
// latency_capture: snapshots the timer on start/stop events, queues each latency in a
// show-ahead FIFO and keeps min/max/sum/count statistics. Optional macro: LATCAP_TIMEOUT_EN.
module latency_capture #(
  parameter int CW      = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          meas_start,
  input  logic          meas_stop,
  input  logic [CW-1:0] timer_count,
  input  logic          res_rd,
  output logic          res_valid,
  output logic [CW-1:0] res_data,
  output logic          fifo_full,
  output logic [7:0]    drop_cnt,
  output logic [15:0]   sample_cnt,
  output logic [CW-1:0] lat_min,
  output logic [CW-1:0] lat_max,
  output logic [23:0]   lat_sum,
  output logic [7:0]    timeout_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("latency_capture: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] snap_q, snap_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [15:0]   sample_cnt_q, sample_cnt_d;
  logic [CW-1:0] lat_min_q, lat_min_d;
  logic [CW-1:0] lat_max_q, lat_max_d;
  logic [23:0]   lat_sum_q, lat_sum_d;

  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] lat;
  logic [24:0]   sum_ext;
  logic          sample_done;
  logic          pop;
  logic          wr_en;

`ifdef LATCAP_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [7:0]  timeout_cnt_q, timeout_cnt_d;
`endif

  // Modulo subtraction handles a timer wrap between start and stop.
  assign lat       = timer_count - snap_q;
  assign res_valid = (count_q != '0);
  assign fifo_full = (count_q == FULL_COUNT);
  assign pop       = res_rd && res_valid;
  assign wr_en     = sample_done && (!fifo_full || pop);

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    sample_done = 1'b0;
`ifdef LATCAP_TIMEOUT_EN
    run_cnt_d     = run_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (meas_start && !meas_stop) begin
          state_d = RUN;
          snap_d  = timer_count;
`ifdef LATCAP_TIMEOUT_EN
          run_cnt_d = '0;
`endif
        end
      end
      RUN: begin
        if (meas_stop) begin
          sample_done = 1'b1;
          state_d     = IDLE;
        end else if (meas_start) begin
          snap_d = timer_count;
`ifdef LATCAP_TIMEOUT_EN
          run_cnt_d = '0;
        end else if (run_cnt_q == TIMEOUT_LAST) begin
          state_d = IDLE;
          if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
        end else begin
          run_cnt_d = run_cnt_q + 16'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_cnt_d   = drop_cnt_q;
    sample_cnt_d = sample_cnt_q;
    lat_min_d    = lat_min_q;
    lat_max_d    = lat_max_q;
    sum_ext      = {1'b0, lat_sum_q} + 25'(lat);
    lat_sum_d    = lat_sum_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (sample_done && !wr_en && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;

    // Statistics track every completed sample, including ones the FIFO had to drop.
    if (sample_done) begin
      if (sample_cnt_q != 16'hFFFF) sample_cnt_d = sample_cnt_q + 16'd1;
      lat_sum_d = sum_ext[24] ? 24'hFFFFFF : sum_ext[23:0];
      if (lat < lat_min_q) lat_min_d = lat;
      if (lat > lat_max_q) lat_max_d = lat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      sample_cnt_q <= '0;
      lat_min_q    <= '1;
      lat_max_q    <= '0;
      lat_sum_q    <= '0;
`ifdef LATCAP_TIMEOUT_EN
      run_cnt_q     <= '0;
      timeout_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_cnt_q   <= drop_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      lat_min_q    <= lat_min_d;
      lat_max_q    <= lat_max_d;
      lat_sum_q    <= lat_sum_d;
`ifdef LATCAP_TIMEOUT_EN
      run_cnt_q     <= run_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= lat;
  end

  assign res_data   = res_valid ? mem[rd_ptr_q] : '0;
  assign drop_cnt   = drop_cnt_q;
  assign sample_cnt = sample_cnt_q;
  assign lat_min    = lat_min_q;
  assign lat_max    = lat_max_q;
  assign lat_sum    = lat_sum_q;

`ifdef LATCAP_TIMEOUT_EN
  assign timeout_cnt = timeout_cnt_q;
`else
  assign timeout_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_latency_capture.sv
// Testbench for latency_capture: directed scenarios plus randomized traffic checked
// against a queue-based measurement model.
module tb_latency_capture;
  localparam int CW    = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        meas_start = 1'b0;
  logic        meas_stop = 1'b0;
  logic [7:0]  timer_count = 8'd0;
  logic        res_rd = 1'b0;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        fifo_full;
  logic [7:0]  drop_cnt;
  logic [15:0] sample_cnt;
  logic [7:0]  lat_min;
  logic [7:0]  lat_max;
  logic [23:0] lat_sum;
  logic [7:0]  timeout_cnt;

  int checks = 0;
  int errors = 0;

  latency_capture #(.CW(CW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .meas_start(meas_start), .meas_stop(meas_stop), .timer_count(timer_count),
    .res_rd(res_rd), .res_valid(res_valid), .res_data(res_data), .fifo_full(fifo_full),
    .drop_cnt(drop_cnt), .sample_cnt(sample_cnt), .lat_min(lat_min), .lat_max(lat_max),
    .lat_sum(lat_sum), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a measurement is open or not; results live in a plain queue.
  bit m_open;
  int m_snap;
  int m_q[$];
  int m_drop, m_cnt, m_min, m_max, m_sum, m_to;
`ifdef LATCAP_TIMEOUT_EN
  int m_elapsed;
`endif

  task automatic model_reset();
    m_open = 0; m_snap = 0; m_q.delete();
    m_drop = 0; m_cnt = 0; m_min = 255; m_max = 0; m_sum = 0; m_to = 0;
  endtask

  task automatic model_step(input bit rst, input bit clr, input bit s, input bit p,
                            input int tc, input bit rd);
    if (rst || clr) begin
      model_reset();
      return;
    end
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (!m_open) begin
      if (s && !p) begin
        m_open = 1; m_snap = tc;
`ifdef LATCAP_TIMEOUT_EN
        m_elapsed = 0;
`endif
      end
    end else if (p) begin
      int lat;
      lat = (tc - m_snap + 256) % 256;
      m_open = 0;
      if (m_q.size() < DEPTH) m_q.push_back(lat);
      else if (m_drop < 255) m_drop++;
      if (m_cnt < 65535) m_cnt++;
      m_sum = (m_sum + lat > 24'hFFFFFF) ? 24'hFFFFFF : m_sum + lat;
      if (lat < m_min) m_min = lat;
      if (lat > m_max) m_max = lat;
    end else if (s) begin
      m_snap = tc;
`ifdef LATCAP_TIMEOUT_EN
      m_elapsed = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed >= TO) begin
        m_open = 0;
        if (m_to < 255) m_to++;
      end
`endif
    end
  endtask

  task automatic tick(input bit s, input bit p, input int tc, input bit rd, input bit clr);
    meas_start = s; meas_stop = p; timer_count = tc[7:0]; res_rd = rd; clear = clr;
    @(posedge clk);
    model_step(reset, clr, s, p, tc & 255, rd);
    #1;
    meas_start = 0; meas_stop = 0; res_rd = 0; clear = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 3, 0, 0);
    reset = 0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d expected 0", res_valid); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0d expected 0", fifo_full); end
    checks++; if (res_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d expected 0", res_data); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d expected 0", drop_cnt); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d expected 0", sample_cnt); end
    checks++; if (lat_min !== 8'hFF) begin errors++; $display("FAIL reset_min got %0d expected 255", lat_min); end
    checks++; if (lat_max !== 8'd0) begin errors++; $display("FAIL reset_max got %0d expected 0", lat_max); end
    checks++; if (lat_sum !== 24'd0) begin errors++; $display("FAIL reset_sum got %0d expected 0", lat_sum); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL reset_timeout got %0d expected 0", timeout_cnt); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    tick(1, 0, 5, 0, 0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0d expected 0", res_valid); end
    tick(0, 1, 42, 0, 0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0d expected 1", res_valid); end
    checks++; if (res_data !== 8'd37) begin errors++; $display("FAIL basic_data got %0d expected 37", res_data); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt got %0d expected 1", sample_cnt); end
    checks++; if (lat_min !== 8'd37) begin errors++; $display("FAIL basic_min got %0d expected 37", lat_min); end
    checks++; if (lat_max !== 8'd37) begin errors++; $display("FAIL basic_max got %0d expected 37", lat_max); end
    checks++; if (lat_sum !== 24'd37) begin errors++; $display("FAIL basic_sum got %0d expected 37", lat_sum); end
    $display("test_basic start@5 stop@42 data=%0d", res_data);
  endtask

  task automatic test_wrap();
    tick(0, 0, 0, 1, 0);
    tick(1, 0, 250, 0, 0);
    tick(0, 1, 4, 0, 0);
    checks++; if (res_data !== 8'd10 || res_valid !== 1'b1) begin errors++; $display("FAIL wrap_data got %0d/%0d expected 10/1", res_data, res_valid); end
    checks++; if (lat_min !== 8'd10) begin errors++; $display("FAIL wrap_min got %0d expected 10", lat_min); end
    tick(1, 1, 7, 0, 0);
    tick(0, 0, 9, 0, 0);
    tick(0, 1, 20, 0, 0);
    checks++; if (sample_cnt !== 16'd2) begin errors++; $display("FAIL both_idle_cnt got %0d expected 2", sample_cnt); end
    $display("test_wrap start@250 stop@4 data=%0d cnt=%0d", res_data, sample_cnt);
  endtask

  task automatic test_rearm();
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 10, 0, 0);
    tick(1, 0, 20, 0, 0);
    tick(0, 1, 30, 0, 0);
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL rearm_cnt got %0d expected 1", sample_cnt); end
    checks++; if (res_data !== 8'd10) begin errors++; $display("FAIL rearm_data got %0d expected 10", res_data); end
    tick(0, 0, 0, 1, 0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rearm_single got valid %0d expected 0", res_valid); end
    $display("test_rearm one sample of 10");
  endtask

  task automatic test_full();
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      tick(1, 0, i * 7, 0, 0);
      tick(0, 1, i * 7 + 3, 0, 0);
    end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag got %0d expected 1", fifo_full); end
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL full_drop got %0d expected 2", drop_cnt); end
    checks++; if (sample_cnt !== 16'd18) begin errors++; $display("FAIL full_cnt got %0d expected 18", sample_cnt); end
    checks++; if (lat_sum !== 24'd54) begin errors++; $display("FAIL full_sum got %0d expected 54", lat_sum); end
    checks++; if (res_data !== 8'd3) begin errors++; $display("FAIL full_head got %0d expected 3", res_data); end
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      tick(1, 0, i * 5, 0, 0);
      tick(0, 1, i * 5 + 3, (i == 16), 0);
    end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_pop_drop got %0d expected 1", drop_cnt); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_pop_flag got %0d expected 1", fifo_full); end
    $display("test_full drop=%0d cnt=%0d", drop_cnt, sample_cnt);
  endtask

  task automatic test_clear_in_run();
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 3, 0, 0);
    tick(0, 0, 5, 0, 1);
    tick(0, 1, 9, 0, 0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %0d expected 0", res_valid); end
    checks++; if (sample_cnt !== 16'd0 || lat_sum !== 24'd0) begin errors++; $display("FAIL clear_stats got cnt %0d sum %0d expected 0 0", sample_cnt, lat_sum); end
    checks++; if (lat_min !== 8'hFF || lat_max !== 8'd0) begin errors++; $display("FAIL clear_minmax got %0d/%0d expected 255/0", lat_min, lat_max); end
    $display("test_clear_in_run no sample");
  endtask

  task automatic test_timeout();
    tick(0, 0, 0, 0, 1);
`ifdef LATCAP_TIMEOUT_EN
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < TO; i++) tick(0, 0, 2 + i, 0, 0);
    checks++; if (timeout_cnt !== 8'd1) begin errors++; $display("FAIL to_cnt got %0d expected 1", timeout_cnt); end
    tick(0, 1, 50, 0, 0);
    checks++; if (res_valid !== 1'b0 || sample_cnt !== 16'd0) begin errors++; $display("FAIL to_idle got valid %0d cnt %0d expected 0 0", res_valid, sample_cnt); end
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) tick(0, 0, 2 + i, 0, 0);
    tick(0, 1, 20, 0, 0);
    checks++; if (res_valid !== 1'b1 || res_data !== 8'd19) begin errors++; $display("FAIL to_stop_wins got %0d/%0d expected 1/19", res_valid, res_data); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL to_stop_cnt got %0d expected 0", timeout_cnt); end
`else
    tick(1, 0, 1, 0, 0);
    for (int i = 0; i < 300; i++) tick(0, 0, 2 + i, 0, 0);
    tick(0, 1, 40, 0, 0);
    checks++; if (res_valid !== 1'b1 || res_data !== 8'd39) begin errors++; $display("FAIL no_to_sample got %0d/%0d expected 1/39", res_valid, res_data); end
    checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL no_to_cnt got %0d expected 0", timeout_cnt); end
`endif
    $display("test_timeout timeout_cnt=%0d", timeout_cnt);
  endtask

  task automatic test_random();
    int t;
    bit s, p, rd, clr;
    t = $urandom_range(0, 255);
    tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      t = t + 1 + (($urandom % 4 == 0) ? $urandom_range(0, 40) : 0);
      s   = ($urandom % 5 == 0);
      p   = ($urandom % 6 == 0);
      rd  = ((i / 400) % 2 == 1) ? ($urandom % 2 == 0) : ($urandom % 25 == 0);
      clr = ($urandom % 700 == 0);
      tick(s, p, t, rd, clr);
      checks++; if (res_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0d expected %0d", i, res_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        checks++; if (res_data !== 8'(m_q[0])) begin errors++; $display("FAIL rnd_data cyc %0d got %0d expected %0d", i, res_data, m_q[0]); end
      end
      checks++; if (fifo_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc %0d got %0d expected %0d", i, fifo_full, m_q.size() == DEPTH); end
      checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rnd_drop cyc %0d got %0d expected %0d", i, drop_cnt, m_drop); end
      checks++; if (sample_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d expected %0d", i, sample_cnt, m_cnt); end
      checks++; if (lat_min !== 8'(m_min) || lat_max !== 8'(m_max)) begin errors++; $display("FAIL rnd_minmax cyc %0d got %0d/%0d expected %0d/%0d", i, lat_min, lat_max, m_min, m_max); end
      checks++; if (lat_sum !== 24'(m_sum)) begin errors++; $display("FAIL rnd_sum cyc %0d got %0d expected %0d", i, lat_sum, m_sum); end
      checks++; if (timeout_cnt !== 8'(m_to)) begin errors++; $display("FAIL rnd_timeout cyc %0d got %0d expected %0d", i, timeout_cnt, m_to); end
    end
    $display("test_random samples=%0d drops=%0d timeouts=%0d", m_cnt, m_drop, m_to);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_rearm();
    test_full();
    test_clear_in_run();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latency_capture.md
Name: latency_capture

Overview:
- Downstream consumer of the 8-bit start/stop cycle timer in the link-latency measurement path.
- Snapshots the free-running timer count on each start event and again on the matching stop event, and forms the per-measurement latency as the modulo difference of the two.
- Pushes each latency into a show-ahead result FIFO and maintains running min/max/sum/count statistics for readout by the slow-control logic.

Parameters:
- CW, 8, width of the timer count and of each latency result.
- DEPTH, 16, result FIFO depth in entries; must be a power of 2 and at least 2.
- TIMEOUT, 200, cycles in RUN before an abort; used only with LATCAP_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear of FIFO, statistics, drop_cnt and FSM; same effect as reset.
- meas_start  input  1  start event; same net as the timer's start input.
- meas_stop  input  1  stop event; same net as the timer's stop input.
- timer_count  input  CW  timer counter value.
- res_rd  input  1  pop request for the result FIFO.
- res_valid  output  1  FIFO not empty.
- res_data  output  CW  FIFO head entry (show-ahead).
- fifo_full  output  1  FIFO holds DEPTH entries.
- drop_cnt  output  8  results lost to a full FIFO; saturates at 255.
- sample_cnt  output  16  completed measurements; saturates at 16'hFFFF.
- lat_min  output  CW  minimum latency.
- lat_max  output  CW  maximum latency.
- lat_sum  output  24  sum of latencies; saturates at 24'hFFFFFF.
- timeout_cnt  output  8  aborted measurements; saturates at 255.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset and clear are synchronous and active-high; reset has priority over everything.
- Output values after reset or clear:
  - res_valid=0, fifo_full=0, res_data=0 (don't-care while res_valid=0).
  - drop_cnt=0, sample_cnt=0, lat_min={CW{1}}, lat_max=0, lat_sum=0, timeout_cnt=0.
  - FSM=IDLE.
- FSM states: IDLE, RUN.
  - IDLE:
    - meas_start=1 with meas_stop=0: start_snap<=timer_count; go to RUN.
    - meas_stop=1 alone: ignored.
    - Both asserted: ignored.
  - RUN:
    - meas_stop=1, regardless of meas_start: lat=(timer_count-start_snap) mod 2^CW; complete the sample; go to IDLE.
    - meas_start=1 with meas_stop=0: re-arm; start_snap<=timer_count; stay in RUN; no sample is produced.
- Sample completion at cycle N:
  - Result is written to the FIFO and the statistics are updated at the N edge.
  - res_valid and the new statistics are visible in cycle N+1.
  - Statistics update: sample_cnt+1, lat_sum+lat (each saturating), lat_min=min(lat_min,lat), lat_max=max(lat_max,lat).
  - Statistics update even when the FIFO write is dropped.
- FIFO:
  - Show-ahead: res_data is the head entry whenever res_valid=1.
  - Pop occurs on res_rd && res_valid; res_rd while empty is ignored.
  - Push while full with no pop: entry discarded, drop_cnt+1 (saturating), FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed and the count is unchanged.
  - Push and pop in the same cycle while empty: push only, because res_valid=0.
  - Pointers are log2(DEPTH) bits and wrap naturally; the occupancy counter is log2(DEPTH)+1 bits.
- A timer count that wraps between start and stop gives the correct modulo result (e.g. 250 -> 4 gives 10).
- Equal snapshots give lat=0, which is a valid sample.
- reset or clear asserted while in RUN abandons the measurement with no sample produced.

Optional Feature:
- Macro: LATCAP_TIMEOUT_EN.
- Defined:
  - A 16-bit run counter clears on entry to RUN and on re-arm, and increments each cycle spent in RUN.
  - When it reaches TIMEOUT with no stop in that cycle: return to IDLE, timeout_cnt+1 (saturating), no FIFO write, no statistics update.
  - A stop in the same cycle as the timeout wins and completes the sample normally.
- Not defined:
  - No run counter is built.
  - RUN waits indefinitely for a stop.
  - timeout_cnt is tied to 0.

Test Plan:
- reset; start with timer_count=5; stop with timer_count=42 -> cycle after stop: res_valid=1, res_data=37, sample_cnt=1, lat_min=lat_max=37, lat_sum=37.
- start@250, stop@4 -> res_data=10; then start and stop both asserted in IDLE -> no sample, sample_cnt unchanged.
- start@10, start@20 (re-arm), stop@30 -> exactly one sample, value 10.
- 18 samples of latency 3 with no reads (DEPTH=16) -> fifo_full=1, drop_cnt=2, sample_cnt=18, lat_sum=54; on the 17th push assert res_rd together with it -> accepted, drop_cnt=1 instead.
- start, then clear asserted in RUN, then stop -> no FIFO entry, all statistics at their reset values.
- LATCAP_TIMEOUT_EN, TIMEOUT=8: start with no stop for 8 cycles -> IDLE, timeout_cnt=1, res_valid=0; stop in exactly cycle 8 -> sample kept, timeout_cnt=0.
